// File: rtl/pcie_dn_ebuf_fetch_ctrl.sv
// Downstream empty-buffer descriptor block fetch scheduler: issues 256 B ring reads,
// throttled by outstanding-tag count and FIFO space, with a lost-completion timeout.
module pcie_dn_ebuf_fetch_ctrl #(
  parameter int unsigned TAG_NUM      = 4,
  parameter int unsigned TMO_CYC      = 50000,
  parameter int unsigned DESC_PER_BLK = 8
) (
  input  logic        PCIE_CLK,
  input  logic        PCIE_RST_N,
  input  logic        CFG_EN,
  input  logic [63:0] CFG_RING_BASE,
  input  logic [15:0] CFG_RING_DEPTH,
  input  logic        DB_VLD,
  output logic        MRD_REQ,
  output logic [63:0] MRD_ADDR,
  output logic [9:0]  MRD_LEN,
  output logic [7:0]  MRD_TAG,
  input  logic        MRD_ACK,
  input  logic        EBUF_RD_REQ,
  input  logic        EBUF_RD_ACK,
  input  logic [9:0]  EBUF_FIFO_FREE,
  output logic [3:0]  STS_OUTSTD,
  output logic [31:0] STS_BLK_CNT,
  output logic        STS_TIMEOUT,
  output logic        STS_ERR
);

  localparam int unsigned TMR_W = $clog2(TMO_CYC + 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [15:0]      idx_q, idx_d;
  logic [7:0]       tag_q, tag_d;
  logic             pend_q, pend_d;
  logic [3:0]       outstd_q, outstd_d;
  logic [31:0]      blk_q, blk_d;
  logic             tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [63:0]      req_addr_q, req_addr_d;
  logic [7:0]       req_tag_q, req_tag_d;
  logic [9:0]       req_len_q, req_len_d;

  logic        accept;
  logic        dis_idle;
  logic        ack_ok;
  logic        tmo_hit;
  logic        can_issue;
  logic [10:0] need;

  assign accept   = (state_q == StIssue) & MRD_ACK;
  assign dis_idle = (state_q == StIdle) & ~CFG_EN;
  assign ack_ok   = EBUF_RD_ACK & (outstd_q != 4'd0);
  assign tmo_hit  = (outstd_q != 4'd0) & ~EBUF_RD_ACK & (timer_q == TMR_W'(TMO_CYC - 1));

  // FIFO must be able to absorb every block already in flight plus the new one.
  assign need      = 11'(DESC_PER_BLK) * (11'(outstd_q) + 11'd1);
  assign can_issue = CFG_EN & pend_q & (outstd_q < 4'(TAG_NUM)) & ~tmo_q &
                     ({1'b0, EBUF_FIFO_FREE} >= need);

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_tag_d  = req_tag_q;
    req_len_d  = req_len_q;
    case (state_q)
      StIdle: begin
        if (can_issue) begin
          state_d    = StIssue;
          req_addr_d = CFG_RING_BASE + {40'd0, idx_q, 8'd0};
          req_tag_d  = tag_q;
          req_len_d  = 10'd64;
        end
      end
      StIssue: begin
        if (MRD_ACK) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    tag_d = tag_q;
    if (dis_idle) begin
      idx_d = 16'd0;
      tag_d = 8'd0;
    end else if (accept) begin
      idx_d = (({1'b0, idx_q} + 17'd1) >= {1'b0, CFG_RING_DEPTH}) ? 16'd0 : idx_q + 16'd1;
      tag_d = (tag_q == 8'(TAG_NUM - 1)) ? 8'd0 : tag_q + 8'd1;
    end
  end

  // A new doorbell or chained request on the accept cycle keeps pend set.
  always_comb begin
    pend_d = pend_q;
    if (dis_idle)                  pend_d = 1'b0;
    else if (DB_VLD | EBUF_RD_REQ) pend_d = 1'b1;
    else if (accept)               pend_d = 1'b0;
  end

  always_comb begin
    outstd_d = outstd_q;
    if (tmo_hit) begin
      outstd_d = 4'd0;
    end else begin
      case ({accept, ack_ok})
        2'b10:   outstd_d = outstd_q + 4'd1;
        2'b01:   outstd_d = outstd_q - 4'd1;
        default: outstd_d = outstd_q;
      endcase
    end
  end

  always_comb begin
    blk_d   = blk_q + {31'd0, ack_ok};
    err_d   = err_q;
    tmo_d   = tmo_q;
    timer_d = timer_q + TMR_W'(1);
    if (dis_idle) begin
      err_d = 1'b0;
      tmo_d = 1'b0;
    end else begin
      if (EBUF_RD_ACK && (outstd_q == 4'd0)) err_d = 1'b1;
      if (tmo_hit)                           tmo_d = 1'b1;
    end
    if ((outstd_q == 4'd0) || EBUF_RD_ACK || tmo_hit) timer_d = '0;
  end

  always_ff @(posedge PCIE_CLK or negedge PCIE_RST_N) begin
    if (!PCIE_RST_N) begin
      state_q    <= StIdle;
      idx_q      <= 16'd0;
      tag_q      <= 8'd0;
      pend_q     <= 1'b0;
      outstd_q   <= 4'd0;
      blk_q      <= 32'd0;
      tmo_q      <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= '0;
      req_addr_q <= 64'd0;
      req_tag_q  <= 8'd0;
      req_len_q  <= 10'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      pend_q     <= pend_d;
      outstd_q   <= outstd_d;
      blk_q      <= blk_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      req_addr_q <= req_addr_d;
      req_tag_q  <= req_tag_d;
      req_len_q  <= req_len_d;
    end
  end

  assign MRD_REQ     = (state_q == StIssue);
  assign MRD_ADDR    = req_addr_q;
  assign MRD_TAG     = req_tag_q;
  assign MRD_LEN     = req_len_q;
  assign STS_OUTSTD  = outstd_q;
  assign STS_BLK_CNT = blk_q;
  assign STS_TIMEOUT = tmo_q;
  assign STS_ERR     = err_q;

endmodule

// File: tb/tb_pcie_dn_ebuf_fetch_ctrl.sv
// Bench for pcie_dn_ebuf_fetch_ctrl: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level reference model (queue of in-flight tags).
module tb_pcie_dn_ebuf_fetch_ctrl;

  localparam int TAG_N = 4;
  localparam int TMO   = 100;

  logic        PCIE_CLK;
  logic        PCIE_RST_N;
  logic        CFG_EN;
  logic [63:0] CFG_RING_BASE;
  logic [15:0] CFG_RING_DEPTH;
  logic        DB_VLD;
  logic        MRD_REQ;
  logic [63:0] MRD_ADDR;
  logic [9:0]  MRD_LEN;
  logic [7:0]  MRD_TAG;
  logic        MRD_ACK;
  logic        EBUF_RD_REQ;
  logic        EBUF_RD_ACK;
  logic [9:0]  EBUF_FIFO_FREE;
  logic [3:0]  STS_OUTSTD;
  logic [31:0] STS_BLK_CNT;
  logic        STS_TIMEOUT;
  logic        STS_ERR;

  pcie_dn_ebuf_fetch_ctrl #(
    .TAG_NUM      (TAG_N),
    .TMO_CYC      (TMO),
    .DESC_PER_BLK (8)
  ) u_dut (
    .PCIE_CLK       (PCIE_CLK),
    .PCIE_RST_N     (PCIE_RST_N),
    .CFG_EN         (CFG_EN),
    .CFG_RING_BASE  (CFG_RING_BASE),
    .CFG_RING_DEPTH (CFG_RING_DEPTH),
    .DB_VLD         (DB_VLD),
    .MRD_REQ        (MRD_REQ),
    .MRD_ADDR       (MRD_ADDR),
    .MRD_LEN        (MRD_LEN),
    .MRD_TAG        (MRD_TAG),
    .MRD_ACK        (MRD_ACK),
    .EBUF_RD_REQ    (EBUF_RD_REQ),
    .EBUF_RD_ACK    (EBUF_RD_ACK),
    .EBUF_FIFO_FREE (EBUF_FIFO_FREE),
    .STS_OUTSTD     (STS_OUTSTD),
    .STS_BLK_CNT    (STS_BLK_CNT),
    .STS_TIMEOUT    (STS_TIMEOUT),
    .STS_ERR        (STS_ERR)
  );

  initial PCIE_CLK = 1'b0;
  always #5 PCIE_CLK = ~PCIE_CLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_req, m_pend, m_tmo, m_err;
  logic [63:0] m_addr;
  logic [7:0]  m_tag;
  int          m_idx, m_tagc, m_timer;
  int unsigned m_blk;
  logic [7:0]  inflight[$];
  int          m_n;
  bit          m_acc, m_off, m_go, m_tmo_now;

  initial begin
    forever begin
      @(posedge PCIE_CLK or negedge PCIE_RST_N);
      if (!PCIE_RST_N) begin
        m_req = 0; m_pend = 0; m_tmo = 0; m_err = 0; m_addr = '0; m_tag = '0;
        m_idx = 0; m_tagc = 0; m_timer = 0; m_blk = 0;
        inflight.delete();
      end else begin
        m_n      = inflight.size();
        m_acc    = m_req && MRD_ACK;
        m_off    = !m_req && !CFG_EN;
        m_go     = !m_req && CFG_EN && m_pend && (m_n < TAG_N) && !m_tmo &&
                   (int'(EBUF_FIFO_FREE) >= 8 * (m_n + 1));
        m_tmo_now = (m_n > 0) && !EBUF_RD_ACK && (m_timer == TMO - 1);
        if (m_n == 0 || EBUF_RD_ACK || m_tmo_now) m_timer = 0;
        else m_timer++;
        if (EBUF_RD_ACK) begin
          if (m_n > 0) begin
            void'(inflight.pop_front());
            m_blk++;
          end else m_err = 1;
        end
        if (DB_VLD || EBUF_RD_REQ) m_pend = 1;
        else if (m_acc) m_pend = 0;
        if (m_acc) begin
          inflight.push_back(m_tag);
          m_idx  = (m_idx + 1) % int'(CFG_RING_DEPTH);
          m_tagc = (m_tagc + 1) % TAG_N;
          m_req  = 0;
        end
        if (m_tmo_now) begin
          inflight.delete();
          m_tmo = 1;
        end
        if (m_off) begin
          m_idx = 0; m_tagc = 0; m_pend = 0; m_tmo = 0; m_err = 0;
        end
        if (m_go) begin
          m_req  = 1;
          m_addr = CFG_RING_BASE + 64'(m_idx) * 64'd256;
          m_tag  = 8'(m_tagc);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge PCIE_CLK);
      if (PCIE_RST_N && chk_en) begin
        check_eq("m_req", MRD_REQ, m_req);
        if (m_req) begin
          check_eq("m_addr", MRD_ADDR, m_addr);
          check_eq("m_tag", MRD_TAG, m_tag);
          check_eq("m_len", MRD_LEN, 64);
        end
        check_eq("m_outstd", STS_OUTSTD, 64'(inflight.size()));
        check_eq("m_blk", STS_BLK_CNT, m_blk);
        check_eq("m_tmo", STS_TIMEOUT, m_tmo);
        check_eq("m_err", STS_ERR, m_err);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCIE_CLK);
      #1;
    end
  endtask

  task automatic pulse_db();
    DB_VLD = 1'b1; step(1); DB_VLD = 1'b0;
  endtask

  task automatic pulse_rdack();
    EBUF_RD_ACK = 1'b1; step(1); EBUF_RD_ACK = 1'b0;
  endtask

  task automatic ack_req();
    MRD_ACK = 1'b1; step(1); MRD_ACK = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max_cyc);
    int n = 0;
    while (!MRD_REQ && n < max_cyc) begin
      step(1);
      n++;
    end
    check_eq(tag, MRD_REQ, 1);
  endtask

  localparam logic [63:0] BASE = 64'h1_0000_0000;

  initial begin
    int n;
    PCIE_RST_N = 0; CFG_EN = 0; CFG_RING_BASE = BASE; CFG_RING_DEPTH = 16'd4;
    DB_VLD = 0; MRD_ACK = 0; EBUF_RD_REQ = 0; EBUF_RD_ACK = 0; EBUF_FIFO_FREE = 10'd512;
    step(3);
    check_eq("rst_req", MRD_REQ, 0);
    check_eq("rst_addr", MRD_ADDR, 0);
    check_eq("rst_tag", MRD_TAG, 0);
    check_eq("rst_len", MRD_LEN, 0);
    check_eq("rst_outstd", STS_OUTSTD, 0);
    check_eq("rst_blk", STS_BLK_CNT, 0);
    check_eq("rst_tmo", STS_TIMEOUT, 0);
    check_eq("rst_err", STS_ERR, 0);
    PCIE_RST_N = 1;
    chk_en = 1'b1;
    step(1);

    // Basic fetch
    CFG_EN = 1;
    pulse_db();
    wait_req("basic_req", 5);
    check_eq("basic_addr", MRD_ADDR, BASE);
    check_eq("basic_tag", MRD_TAG, 0);
    check_eq("basic_len", MRD_LEN, 64);
    ack_req();
    check_eq("basic_outstd1", STS_OUTSTD, 1);
    pulse_rdack();
    check_eq("basic_outstd0", STS_OUTSTD, 0);
    check_eq("basic_blk", STS_BLK_CNT, 1);

    // Ring wrap and chaining through RD_REQ
    CFG_EN = 0; step(2);
    CFG_RING_DEPTH = 16'd2; CFG_EN = 1;
    pulse_db();
    for (int i = 0; i < 3; i++) begin
      wait_req("wrap_req", 5);
      check_eq("wrap_addr", MRD_ADDR, BASE + 64'(i % 2) * 64'd256);
      check_eq("wrap_tag", MRD_TAG, 64'(i));
      ack_req();
      EBUF_RD_ACK = 1; EBUF_RD_REQ = (i < 2); step(1);
      EBUF_RD_ACK = 0; EBUF_RD_REQ = 0;
    end

    // FIFO space throttle
    pulse_db(); wait_req("thr_req0", 5); ack_req();
    EBUF_FIFO_FREE = 10'd15;
    pulse_db(); step(6);
    check_eq("thr_free15", MRD_REQ, 0);
    EBUF_FIFO_FREE = 10'd16;
    wait_req("thr_free16", 3);
    ack_req();
    // Tag limit throttle
    EBUF_FIFO_FREE = 10'd512;
    pulse_db(); wait_req("thr_req2", 5); ack_req();
    pulse_db(); wait_req("thr_req3", 5); ack_req();
    check_eq("thr_outstd4", STS_OUTSTD, 4);
    pulse_db(); step(5);
    check_eq("thr_tag_full", MRD_REQ, 0);
    pulse_rdack();
    wait_req("thr_release", 2);

    // Simultaneous MRD_ACK / RD_ACK / DB_VLD
    pulse_rdack();
    check_eq("sim_pre", STS_OUTSTD, 2);
    MRD_ACK = 1; EBUF_RD_ACK = 1; DB_VLD = 1; step(1);
    MRD_ACK = 0; EBUF_RD_ACK = 0; DB_VLD = 0;
    check_eq("sim_outstd", STS_OUTSTD, 2);
    wait_req("sim_second", 3);
    ack_req();
    check_eq("sim_outstd3", STS_OUTSTD, 3);

    // Timeout
    pulse_rdack();
    n = 0;
    while (!STS_TIMEOUT && n < 200) begin
      step(1);
      n++;
    end
    check_eq("tmo_cycles", 64'(n), TMO);
    check_eq("tmo_outstd", STS_OUTSTD, 0);
    pulse_db(); step(5);
    check_eq("tmo_blocked", MRD_REQ, 0);
    CFG_EN = 0; step(2);
    check_eq("tmo_cleared", STS_TIMEOUT, 0);
    CFG_EN = 1; step(1);

    // Spurious RD_ACK
    pulse_rdack();
    check_eq("err_set", STS_ERR, 1);
    check_eq("err_blk", STS_BLK_CNT, 8);
    CFG_EN = 0; step(2);
    check_eq("err_cleared", STS_ERR, 0);
    CFG_EN = 1;

    // Disable while a request is pending
    pulse_db();
    wait_req("dis_req", 5);
    check_eq("dis_addr0", MRD_ADDR, BASE);
    CFG_EN = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check_eq("dis_hold_req", MRD_REQ, 1);
      check_eq("dis_hold_addr", MRD_ADDR, BASE);
      check_eq("dis_hold_tag", MRD_TAG, 0);
    end
    ack_req(); step(2);
    check_eq("dis_no_req", MRD_REQ, 0);
    CFG_EN = 1;
    pulse_db();
    wait_req("dis_re_req", 5);
    check_eq("dis_idx0", MRD_ADDR, BASE);
    check_eq("dis_tag0", MRD_TAG, 0);
    ack_req();
    pulse_rdack(); pulse_rdack();

    // Random traffic
    CFG_EN = 0; step(2);
    CFG_RING_BASE = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FF00;
    CFG_RING_DEPTH = 16'd3;
    CFG_EN = 1;
    for (int c = 0; c < 1500; c++) begin
      DB_VLD         = ($urandom_range(0, 9) == 0);
      EBUF_RD_REQ    = ($urandom_range(0, 19) == 0);
      MRD_ACK        = ($urandom_range(0, 1) == 1);
      EBUF_RD_ACK    = ($urandom_range(0, 7) == 0);
      EBUF_FIFO_FREE = 10'($urandom_range(0, 60));
      if ($urandom_range(0, 99) == 0) CFG_EN = ~CFG_EN;
      step(1);
    end
    DB_VLD = 0; EBUF_RD_REQ = 0; MRD_ACK = 0; EBUF_RD_ACK = 0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_dn_ebuf_fetch_ctrl.md
Name: pcie_dn_ebuf_fetch_ctrl

Overview:
Schedules downstream memory-read requests that fetch empty-buffer descriptor blocks from a host ring. Each block is 256 B and holds 8 × 32 B descriptors.
Sits beside the downstream completion parser. Consumes that parser's per-block RD_ACK (block done) and RD_REQ (host flags more descriptors) pulses to pace further fetches.
Throttles by outstanding-tag count and by free space in the empty-buffer FIFO. Detects lost completions with a timeout.

Parameters:
TAG_NUM, 4, max outstanding block reads (1..8); tags cycle 0..TAG_NUM-1
TMO_CYC, 50000, PCIE_CLK cycles without a block completion (while reads are outstanding) before declaring timeout
DESC_PER_BLK, 8, descriptors per fetched block; fixed, used in the FIFO space check

Ports:
PCIE_CLK  in  1  clock
PCIE_RST_N  in  1  asynchronous active-low reset
CFG_EN  in  1  fetch enable; low = idle and clear ring index, pending flag and sticky status
CFG_RING_BASE  in  64  host byte address of ring block 0; 256 B aligned
CFG_RING_DEPTH  in  16  ring size in blocks; must be ≥1
DB_VLD  in  1  host doorbell pulse: new descriptors available
MRD_REQ  out  1  read request to the TLP generator
MRD_ADDR  out  64  request address
MRD_LEN  out  10  request length in DW; constant 64
MRD_TAG  out  8  request tag
MRD_ACK  in  1  TLP generator accepted the request
EBUF_RD_REQ  in  1  pulse from the completion parser: last descriptor flags more available
EBUF_RD_ACK  in  1  pulse from the completion parser: one block fully received
EBUF_FIFO_FREE  in  10  free entries in the empty-buffer FIFO
STS_OUTSTD  out  4  outstanding block reads
STS_BLK_CNT  out  32  blocks completed; wraps
STS_TIMEOUT  out  1  sticky timeout
STS_ERR  out  1  sticky: RD_ACK received with zero outstanding

Behaviour:
- Reset: all outputs 0.
  - Internal state at reset: state IDLE, ring index 0, tag counter 0, pend 0, timer 0.
- pend flag:
  - Set by DB_VLD or EBUF_RD_REQ.
  - Cleared on the cycle MRD_REQ&MRD_ACK.
  - If a set and a clear occur in the same cycle, set wins.
- FSM IDLE → ISSUE when all of the following hold:
  - CFG_EN=1 and pend=1 and STS_OUTSTD<TAG_NUM and STS_TIMEOUT=0;
  - EBUF_FIFO_FREE ≥ DESC_PER_BLK*(STS_OUTSTD+1).
  - Evaluated on registered values; MRD_REQ rises the cycle after the condition is true.
- ISSUE:
  - MRD_REQ=1; MRD_ADDR = CFG_RING_BASE + (idx<<8); MRD_TAG = tag counter; MRD_LEN = 64.
  - All request fields hold stable until MRD_ACK.
  - On MRD_REQ&MRD_ACK: MRD_REQ drops the next cycle; idx increments, wrapping to 0 after CFG_RING_DEPTH-1; tag counter increments mod TAG_NUM; outstanding count +1; state → IDLE.
  - Minimum spacing between accepted requests is 2 cycles.
- Outstanding counter:
  - Decrements on EBUF_RD_ACK.
  - Increment and decrement in the same cycle: net unchanged.
  - RD_ACK while count=0: count stays 0, STS_ERR set, STS_BLK_CNT unchanged.
- STS_BLK_CNT: +1 per EBUF_RD_ACK while count>0.
- Completions return in issue order. The tag is informational only; no per-tag tracking.
- Timeout:
  - Timer counts while outstanding>0 and resets to 0 on each EBUF_RD_ACK or when outstanding=0.
  - Timer reaching TMO_CYC-1: STS_TIMEOUT set; outstanding forced to 0; no further issue until CFG_EN is cycled low.
- CFG_EN falling:
  - In IDLE: idx, tag counter, pend, STS_TIMEOUT and STS_ERR cleared next cycle.
  - In ISSUE: the request is not withdrawn. Wait for MRD_ACK, then IDLE, then apply the clears above.
  - Outstanding reads still drain via RD_ACK.
- CFG_RING_BASE and CFG_RING_DEPTH are static while CFG_EN=1.
- Reset mid-ISSUE: MRD_REQ drops asynchronously; there is no completion bookkeeping across reset.

Test Plan:
- Basic fetch: BASE=0x1_0000_0000, DEPTH=4, FREE=512, one DB_VLD → one MRD_REQ, ADDR=0x1_0000_0000, TAG=0, LEN=64; ACK → OUTSTD=1; RD_ACK → OUTSTD=0, BLK_CNT=1.
- Wrap and chaining: DEPTH=2; DB_VLD, then RD_REQ pulses after each RD_ACK → addresses BASE, BASE+0x100, BASE (index wrap); tags 0,1,2.
- Throttle:
  - FREE=15 → no request; FREE=16 with OUTSTD=1 → issue.
  - TAG_NUM=4 with 4 outstanding → held until an RD_ACK, then issue within 2 cycles.
- Simultaneous events: MRD_ACK and RD_ACK in the same cycle with OUTSTD=2 → stays 2; DB_VLD on the MRD_ACK cycle → pend remains 1 and a second request follows.
- Timeout/error:
  - TMO_CYC=100, no RD_ACK → STS_TIMEOUT at cycle 100, OUTSTD=0, DB_VLD ignored; CFG_EN 0→1 clears it.
  - Spurious RD_ACK with OUTSTD=0 → STS_ERR=1.
- Disable mid-request: CFG_EN low while MRD_REQ=1 with MRD_ACK delayed 5 cycles → MRD_REQ held with the same ADDR/TAG until ACK, then idx=0 and no new requests.
